pll_cfg_seq: RTL
================

Name: pll_cfg_seq

Overview:
- Avalon-MM initiator that programs a reconfigurable Cyclone V PLL through its reconfiguration core (pll_reconfig), which drives the PLL's reconfig_to_pll / reconfig_from_pll buses.
- On a request it latches a counter set (N, M, C0, C1, optional fractional K) and writes it to the core in polling mode. It then starts reconfiguration, polls status and waits for PLL lock.
- Sits in sys/ beside the video/audio PLL instances and replaces ad-hoc HPS-driven register writes for core-side clock switching (e.g. PAL/NTSC pixel clock).

Parameters:
- POLL_GAP, 4, idle cycles between successive status reads.
- POLL_MAX, 1024, status reads before declaring a reconfig timeout.
- LOCK_TO, 1048576, cycles to wait for locked after reconfig completes.

Ports:
- refclk  in  1  management clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_req  in  1  one-cycle start pulse; ignored while busy.
- cfg_n  in  18  N counter word {odd, bypass, hi[7:0], lo[7:0]}.
- cfg_m  in  18  M counter word, same format.
- cfg_c0  in  18  C0 counter word, same format; block prepends index 5'd0.
- cfg_c1  in  18  C1 counter word; block prepends index 5'd1.
- cfg_k  in  32  fractional K value.
- pll_locked  in  1  PLL locked, already synchronised to refclk.
- mgmt_address  out  6  Avalon address.
- mgmt_write  out  1  write strobe.
- mgmt_read  out  1  read strobe.
- mgmt_writedata  out  32  write data.
- mgmt_readdata  in  32  read data; valid in the cycle mgmt_waitrequest is low with mgmt_read high.
- mgmt_waitrequest  in  1  stall; strobe, address and data held while high.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on successful lock.
- error  out  1  sticky: timeout occurred; cleared by the next accepted cfg_req or by rst.

Behaviour:
- Reset values: mgmt_write=0, mgmt_read=0, mgmt_address=0, mgmt_writedata=0, busy=0, done=0, error=0, FSM=IDLE. Reset mid-sequence aborts immediately; no Avalon cleanup cycle.
- All cfg_* inputs are latched on the accepted cfg_req; later changes do not affect the sequence in progress.
- States and transitions:
  - IDLE: on cfg_req go to WR_MODE, set busy, clear error.
  - WR_MODE (addr 0, data 1): polling mode.
  - WR_N (addr 3), WR_M (addr 4).
  - WR_C0 (addr 5, data {9'b0, 5'd0, cfg_c0}).
  - WR_C1 (addr 5, data {9'b0, 5'd1, cfg_c1}).
  - WR_K (addr 7): see Optional Feature.
  - WR_START (addr 2, data 1).
  - GAP: counts POLL_GAP cycles, then RD_STAT.
  - RD_STAT (addr 1, read): on completion, if readdata[0]=1 go to WAIT_LOCK. Otherwise increment the poll count; if the count reaches POLL_MAX go to FAIL, else go to GAP.
  - WAIT_LOCK: counter starts at 0. When pll_locked=1 go to DONE. When the counter reaches LOCK_TO-1 with pll_locked still 0 go to FAIL.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
  - FAIL: error=1, busy=0, return to IDLE.
- Write states assert mgmt_write from the state-entry cycle and advance on the first cycle with mgmt_waitrequest=0. mgmt_write and mgmt_read are never high together.
- Minimum latency with waitrequest always low and immediate status/lock: 7 write cycles (6 without K), then POLL_GAP, one read, one lock-check cycle, then done.
- Counters saturate; they never wrap. Each counter is sized to its parameter width (clog2).

Optional Feature:
- Macro PLL_CFG_FRAC_K_EN.
- Defined: WR_K writes cfg_k to addr 7; cfg_k is latched.
- Undefined: the WR_K state and the cfg_k register are removed, the cfg_k port remains but is unused, and WR_C1 goes straight to WR_START.

Decomposition:
- Shared package pll_cfg_pkg holds:
  - address constants: PLLCFG_A_MODE=0, A_STATUS=1, A_START=2, A_N=3, A_M=4, A_C=5, A_K=7;
  - the state enum;
  - the counter-word typedef (18 bits).
- One sub-module, pll_cfg_avm_port, is natural. It handles the single-transaction Avalon handshake (req/ack, waitrequest hold) used by every write and read state.

Test Plan:
- waitrequest=0, status returns 1 on the first read, locked rises 10 cycles later, K enabled -> exact sequence addr 0,3,4,5,5,7,2 writes then one read of addr 1; C0 data 0x000xxxxx with bits[22:18]=0, C1 bits[22:18]=1; one-cycle done pulse; busy falls in the same cycle.
- waitrequest held high for 3 cycles on each transaction -> address/data/strobe stable throughout; same write order; done asserted.
- Status bit0 stays 0, POLL_MAX=8 -> exactly 8 reads spaced by POLL_GAP idle cycles, then error=1, busy=0, no done.
- pll_locked never rises, LOCK_TO=100 -> error=1 exactly 100 cycles after WAIT_LOCK entry; a new cfg_req clears error.
- rst asserted during WR_M -> next cycle all outputs 0, FSM idle; a new cfg_req restarts from WR_MODE. cfg_req while busy is ignored and the latched cfg values are unchanged.
- Build without PLL_CFG_FRAC_K_EN -> no addr 7 write; 6 writes precede start.

Source files
------------

// File: rtl/pll_cfg_seq_pkg.sv
// pll_cfg_pkg: reconfiguration-core register map, sequencer state encoding and counter-word type.
// The S_WR_K state only exists when PLL_CFG_FRAC_K_EN is defined.
package pll_cfg_pkg;

  localparam int PLLCFG_AW = 6;
  localparam int PLLCFG_DW = 32;

  localparam logic [PLLCFG_AW-1:0] PLLCFG_A_MODE   = 6'd0;
  localparam logic [PLLCFG_AW-1:0] PLLCFG_A_STATUS = 6'd1;
  localparam logic [PLLCFG_AW-1:0] PLLCFG_A_START  = 6'd2;
  localparam logic [PLLCFG_AW-1:0] PLLCFG_A_N      = 6'd3;
  localparam logic [PLLCFG_AW-1:0] PLLCFG_A_M      = 6'd4;
  localparam logic [PLLCFG_AW-1:0] PLLCFG_A_C      = 6'd5;
  localparam logic [PLLCFG_AW-1:0] PLLCFG_A_K      = 6'd7;

  // {odd, bypass, hi[7:0], lo[7:0]}
  typedef logic [17:0] cnt_word_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_MODE,
    S_WR_N,
    S_WR_M,
    S_WR_C0,
    S_WR_C1,
`ifdef PLL_CFG_FRAC_K_EN
    S_WR_K,
`endif
    S_WR_START,
    S_GAP,
    S_RD_STAT,
    S_WAIT_LOCK,
    S_DONE,
    S_FAIL
  } state_e;

  // The C register takes the counter index in bits [22:18] above the counter word.
  function automatic logic [PLLCFG_DW-1:0] c_counter_data(input logic [4:0] idx,
                                                          input cnt_word_t word);
    return {9'b0, idx, word};
  endfunction

endpackage

// File: rtl/pll_cfg_seq_if.sv
// Avalon-MM management bus between pll_cfg_seq (master) and the pll_reconfig core (slave).
interface pll_cfg_seq_if;
  import pll_cfg_pkg::*;

  logic [PLLCFG_AW-1:0] mgmt_address;
  logic                 mgmt_write;
  logic                 mgmt_read;
  logic [PLLCFG_DW-1:0] mgmt_writedata;
  logic [PLLCFG_DW-1:0] mgmt_readdata;
  logic                 mgmt_waitrequest;

  modport master (
    output mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
    input  mgmt_readdata, mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
    output mgmt_readdata, mgmt_waitrequest
  );
endinterface

// File: rtl/pll_cfg_seq_avm_port.sv
// pll_cfg_avm_port: one Avalon-MM transaction at a time; start_i loads a command, ack_o marks
// the cycle it completes. Strobe, address and data are registered and held through waitrequest.
module pll_cfg_avm_port
  import pll_cfg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 we_i,
  input  logic [PLLCFG_AW-1:0] addr_i,
  input  logic [PLLCFG_DW-1:0] wdata_i,
  output logic                 ack_o,
  output logic [PLLCFG_DW-1:0] rdata_o,
  pll_cfg_seq_if.master        avm
);

  logic                 write_q, write_d;
  logic                 read_q, read_d;
  logic [PLLCFG_AW-1:0] addr_q, addr_d;
  logic [PLLCFG_DW-1:0] wdata_q, wdata_d;

  assign ack_o   = (write_q | read_q) & ~avm.mgmt_waitrequest;
  assign rdata_o = avm.mgmt_readdata;

  // A start arriving with an ack chains the next command with no idle cycle in between.
  always_comb begin
    write_d = write_q;
    read_d  = read_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start_i) begin
      write_d = we_i;
      read_d  = ~we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end else if (ack_o) begin
      write_d = 1'b0;
      read_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      write_q <= write_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign avm.mgmt_write     = write_q;
  assign avm.mgmt_read      = read_q;
  assign avm.mgmt_address   = addr_q;
  assign avm.mgmt_writedata = wdata_q;

endmodule

// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq: programs a Cyclone V PLL through pll_reconfig (polling mode) and waits for lock.
// Define PLL_CFG_FRAC_K_EN to also write the fractional K register.
module pll_cfg_seq
  import pll_cfg_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1024,
  parameter int LOCK_TO  = 1048576
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 cfg_req,
  input  cnt_word_t            cfg_n,
  input  cnt_word_t            cfg_m,
  input  cnt_word_t            cfg_c0,
  input  cnt_word_t            cfg_c1,
  input  logic [31:0]          cfg_k,
  input  logic                 pll_locked,
  pll_cfg_seq_if.master        mgmt,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int POLL_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam int LOCK_W = (LOCK_TO  > 1) ? $clog2(LOCK_TO)  : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TO - 1);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  cnt_word_t           n_q, n_d, m_q, m_d, c0_q, c0_d, c1_q, c1_d;
`ifdef PLL_CFG_FRAC_K_EN
  logic [31:0]         k_q, k_d;
`else
  logic                unused_cfg_k;
  assign unused_cfg_k = ^cfg_k;
`endif

  logic                 ack;
  logic [PLLCFG_DW-1:0] rdata;
  logic                 req_start, req_we, req_go;
  logic [PLLCFG_AW-1:0] req_addr;
  logic [PLLCFG_DW-1:0] req_wdata;
  logic                 unused_rdata;

  assign unused_rdata = ^rdata[PLLCFG_DW-1:1];

  pll_cfg_avm_port u_port (
    .clk     (refclk),
    .rst     (rst),
    .start_i (req_start),
    .we_i    (req_we),
    .addr_i  (req_addr),
    .wdata_i (req_wdata),
    .ack_o   (ack),
    .rdata_o (rdata),
    .avm     (mgmt)
  );

  // Next-state logic; DONE/FAIL accept a new request just like IDLE so none is lost.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    gap_d   = gap_q;
    poll_d  = poll_q;
    lock_d  = lock_q;
    n_d     = n_q;
    m_d     = m_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
`ifdef PLL_CFG_FRAC_K_EN
    k_d     = k_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (cfg_req) begin
          state_d = S_WR_MODE;
          busy_d  = 1'b1;
          error_d = 1'b0;
          poll_d  = '0;
          n_d     = cfg_n;
          m_d     = cfg_m;
          c0_d    = cfg_c0;
          c1_d    = cfg_c1;
`ifdef PLL_CFG_FRAC_K_EN
          k_d     = cfg_k;
`endif
        end
      end
      S_WR_MODE: if (ack) state_d = S_WR_N;
      S_WR_N:    if (ack) state_d = S_WR_M;
      S_WR_M:    if (ack) state_d = S_WR_C0;
      S_WR_C0:   if (ack) state_d = S_WR_C1;
`ifdef PLL_CFG_FRAC_K_EN
      S_WR_C1:   if (ack) state_d = S_WR_K;
      S_WR_K:    if (ack) state_d = S_WR_START;
`else
      S_WR_C1:   if (ack) state_d = S_WR_START;
`endif
      S_WR_START: begin
        if (ack) begin
          gap_d   = '0;
          state_d = (POLL_GAP == 0) ? S_RD_STAT : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_RD_STAT;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      S_RD_STAT: begin
        if (ack) begin
          if (rdata[0]) begin
            state_d = S_WAIT_LOCK;
            lock_d  = '0;
          end else if (poll_q == POLL_LAST) begin
            state_d = S_FAIL;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            poll_d  = poll_q + POLL_W'(1);
            gap_d   = '0;
            state_d = (POLL_GAP == 0) ? S_RD_STAT : S_GAP;
          end
        end
      end
      S_WAIT_LOCK: begin
        if (pll_locked) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (lock_q == LOCK_LAST) begin
          state_d = S_FAIL;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          lock_d  = lock_q + LOCK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A bus command is launched on the edge that enters a bus state, so the strobe is
  // already up in the state's first cycle.
  assign req_go = (state_d != state_q) || ack;

  always_comb begin
    req_start = 1'b0;
    req_we    = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    case (state_d)
      S_WR_MODE:  begin req_start = req_go; req_addr = PLLCFG_A_MODE;  req_wdata = 32'd1; end
      S_WR_N:     begin req_start = req_go; req_addr = PLLCFG_A_N;     req_wdata = 32'(n_q); end
      S_WR_M:     begin req_start = req_go; req_addr = PLLCFG_A_M;     req_wdata = 32'(m_q); end
      S_WR_C0:    begin req_start = req_go; req_addr = PLLCFG_A_C;     req_wdata = c_counter_data(5'd0, c0_q); end
      S_WR_C1:    begin req_start = req_go; req_addr = PLLCFG_A_C;     req_wdata = c_counter_data(5'd1, c1_q); end
`ifdef PLL_CFG_FRAC_K_EN
      S_WR_K:     begin req_start = req_go; req_addr = PLLCFG_A_K;     req_wdata = k_q; end
`endif
      S_WR_START: begin req_start = req_go; req_addr = PLLCFG_A_START; req_wdata = 32'd1; end
      S_RD_STAT:  begin req_start = req_go; req_addr = PLLCFG_A_STATUS; req_we = 1'b0; end
      default:    req_start = 1'b0;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      gap_q   <= '0;
      poll_q  <= '0;
      lock_q  <= '0;
      n_q     <= '0;
      m_q     <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
`ifdef PLL_CFG_FRAC_K_EN
      k_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      lock_q  <= lock_d;
      n_q     <= n_d;
      m_q     <= m_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
`ifdef PLL_CFG_FRAC_K_EN
      k_q     <= k_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule
